muldiv_sequencer: RTL

Iterative signed multiply/divide engine with its own sequencer. It serves the multicycle CPU's MULT and DIV instructions. The control unit issues a one-cycle start pulse with operands from A/B. The block runs a fixed WIDTH-iteration Booth multiply or restoring divide, then presents 64-bit results on hi/lo for the Hi/Lo registers and flags divide-by-zero for the exception path.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned CntWidth     = $clog2(DefaultWidth) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StFinish
    } muldiv_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative signed Booth multiply / restoring divide sharing one accumulator,
// one shift register pair and one adder/subtractor; results land on hi/lo.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    muldiv_state_e    state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / divide remainder
    logic [WIDTH-1:0] q_q, q_d;         // multiplier / quotient shift register
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor magnitude
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH+1:0] add_a, add_b, sum;
    logic             add_sub;
    logic [WIDTH:0]   acc_new;
    logic [WIDTH:0]   r_shift;
    logic             ge;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign abs_a   = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b   = op_b[WIDTH-1] ? -op_b : op_b;
    assign r_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};

    // The single shared adder: Booth add/sub of sign-extended M, or trial subtract of |b|.
    always_comb begin
        if (state_q == StDiv) begin
            add_a   = {1'b0, r_shift};
            add_b   = {2'b00, m_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {acc_q[WIDTH], acc_q};
            add_b   = {{2{m_q[WIDTH-1]}}, m_q};
            add_sub = q_q[0] & ~qm1_q;
        end
        sum = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    assign ge = ~sum[WIDTH+1];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        acc_new    = acc_q;

        unique case (state_q)
            StIdle: begin
                if (mult_start) begin
                    acc_d   = '0;
                    m_d     = op_a;
                    q_d     = op_b;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StMult;
                end else if (div_start) begin
                    if (op_b == '0) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        state_d    = StFinish;
                    end else begin
                        acc_d   = '0;
                        q_d     = abs_a;
                        m_d     = abs_b;
                        qneg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        rneg_d  = op_a[WIDTH-1];
                        cnt_d   = '0;
                        state_d = StDiv;
                    end
                end
            end
            StMult: begin
                if (q_q[0] != qm1_q) begin
                    acc_new = sum[WIDTH:0];
                end
                acc_d = {acc_new[WIDTH], acc_new[WIDTH:1]};
                q_d   = {acc_new[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    hi_d    = acc_d[WIDTH-1:0];
                    lo_d    = q_d;
                    done_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StDiv: begin
                acc_d = ge ? sum[WIDTH:0] : r_shift;
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    lo_d    = qneg_q ? -q_d : q_d;
                    hi_d    = rneg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
